// File: rtl/alu_pipe_if.sv
// Issue/writeback bundle of the ALU functional unit.
// Handshakes: a transfer occurs on a rising edge where valid && ready are both high;
// a producer holding valid keeps its payload stable until that edge.
interface alu_pipe_if #(
    parameter int XLEN = 64,
    parameter int ROBW = 7,
    parameter int PRW  = 7
);
    logic            i_vld;
    logic            o_rdy;
    logic [4:0]      i_op;
    logic [XLEN-1:0] i_src0;
    logic [XLEN-1:0] i_src1;
    logic [ROBW-1:0] i_rob_idx;
    logic            i_rd_wen;
    logic [PRW-1:0]  i_iprd_idx;
    logic            i_flush;
    logic            o_willwrite_vld;
    logic [PRW-1:0]  o_willwrite_rdidx;
    logic [XLEN-1:0] o_willwrite_data;
    logic            o_vld;
    logic            i_wb_rdy;
    logic [ROBW-1:0] o_rob_idx;
    logic            o_rd_wen;
    logic [PRW-1:0]  o_iprd_idx;
    logic [XLEN-1:0] o_result;
    logic [31:0]     o_op_cnt;

    modport master (
        output i_vld, i_op, i_src0, i_src1, i_rob_idx, i_rd_wen, i_iprd_idx,
               i_flush, i_wb_rdy,
        input  o_rdy, o_willwrite_vld, o_willwrite_rdidx, o_willwrite_data,
               o_vld, o_rob_idx, o_rd_wen, o_iprd_idx, o_result, o_op_cnt
    );

    modport slave (
        input  i_vld, i_op, i_src0, i_src1, i_rob_idx, i_rd_wen, i_iprd_idx,
               i_flush, i_wb_rdy,
        output o_rdy, o_willwrite_vld, o_willwrite_rdidx, o_willwrite_data,
               o_vld, o_rob_idx, o_rd_wen, o_iprd_idx, o_result, o_op_cnt
    );
endinterface

// File: rtl/alu_pipe.sv
// Integer ALU functional unit: operand stage feeding a combinational ALU, then
// DEPTH-1 result stages, all elastic with per-stage back-pressure and flush.
module alu_pipe #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int ROBW  = 7,
    parameter int PRW   = 7
) (
    input logic     clk,
    input logic     rst,
    alu_pipe_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] OP_LUI  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_ADDW = 5'd3;
    localparam logic [4:0] OP_SUBW = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLLW = 5'd8;
    localparam logic [4:0] OP_SRLW = 5'd9;
    localparam logic [4:0] OP_SRAW = 5'd10;
    localparam logic [4:0] OP_XOR  = 5'd11;
    localparam logic [4:0] OP_OR   = 5'd12;
    localparam logic [4:0] OP_AND  = 5'd13;
    localparam logic [4:0] OP_SLT  = 5'd14;
    localparam logic [4:0] OP_SLTU = 5'd15;

    // Stage 1: operands and tags
    logic            s1_vld;
    logic [4:0]      s1_op;
    logic [XLEN-1:0] s1_src0;
    logic [XLEN-1:0] s1_src1;
    logic [ROBW-1:0] s1_rob_idx;
    logic            s1_rd_wen;
    logic [PRW-1:0]  s1_iprd_idx;

    // Stages 2..DEPTH: result and tags
    logic [DEPTH:2]  sk_vld;
    logic [XLEN-1:0] sk_result  [2:DEPTH];
    logic [ROBW-1:0] sk_rob_idx [2:DEPTH];
    logic            sk_rd_wen  [2:DEPTH];
    logic [PRW-1:0]  sk_iprd_idx[2:DEPTH];

    logic [DEPTH:1]  stg_vld;
    logic [DEPTH:1]  can_take;
    logic            accept;
    logic [31:0]     op_cnt_q;

    assign stg_vld = {sk_vld, s1_vld};

    // Stage k can load when it, or every occupied stage downstream of it, moves on.
    // Written as a downstream scan so there is no combinational chain through can_take.
    always_comb begin
        can_take = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            can_take[k] = bus.i_wb_rdy;
            for (int j = k; j <= DEPTH; j++) begin
                if (!stg_vld[j]) can_take[k] = 1'b1;
            end
        end
    end

    assign accept = bus.i_vld && can_take[1];

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [SHW-1:0]  shamt;
    logic [4:0]      shamt_w;
    logic [31:0]     w_res;
    logic            lt_s;
    logic            lt_u;
    logic [XLEN-1:0] alu_res;

    always_comb begin
        shamt   = s1_src1[SHW-1:0];
        shamt_w = s1_src1[4:0];
        lt_s    = $signed(s1_src0) < $signed(s1_src1);
        lt_u    = s1_src0 < s1_src1;
        w_res   = '0;
        alu_res = '0;
        case (s1_op)
            OP_LUI:  alu_res = sext32({s1_src1[19:0], 12'b0});
            OP_ADD:  alu_res = s1_src0 + s1_src1;
            OP_SUB:  alu_res = s1_src0 - s1_src1;
            OP_ADDW: begin
                w_res   = s1_src0[31:0] + s1_src1[31:0];
                alu_res = sext32(w_res);
            end
            OP_SUBW: begin
                w_res   = s1_src0[31:0] - s1_src1[31:0];
                alu_res = sext32(w_res);
            end
            OP_SLL:  alu_res = s1_src0 << shamt;
            OP_SRL:  alu_res = s1_src0 >> shamt;
            OP_SRA:  alu_res = $signed(s1_src0) >>> shamt;
            OP_SLLW: begin
                w_res   = s1_src0[31:0] << shamt_w;
                alu_res = sext32(w_res);
            end
            OP_SRLW: begin
                w_res   = s1_src0[31:0] >> shamt_w;
                alu_res = sext32(w_res);
            end
            OP_SRAW: begin
                w_res   = $signed(s1_src0[31:0]) >>> shamt_w;
                alu_res = sext32(w_res);
            end
            OP_XOR:  alu_res = s1_src0 ^ s1_src1;
            OP_OR:   alu_res = s1_src0 | s1_src1;
            OP_AND:  alu_res = s1_src0 & s1_src1;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            default: alu_res = '0;
        endcase
    end

    // Valids and counter; reset wins over flush, flush wins over any advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            sk_vld   <= '0;
            op_cnt_q <= '0;
        end else begin
            if (sk_vld[DEPTH] && bus.i_wb_rdy) op_cnt_q <= op_cnt_q + 32'd1;
            if (bus.i_flush) begin
                s1_vld <= 1'b0;
                sk_vld <= '0;
            end else begin
                if (can_take[1]) s1_vld <= bus.i_vld;
                for (int k = 2; k <= DEPTH; k++) begin
                    if (can_take[k]) sk_vld[k] <= stg_vld[k-1];
                end
            end
        end
    end

    // Payload registers load only on a real transfer, so a stalled stage holds.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op       <= bus.i_op;
            s1_src0     <= bus.i_src0;
            s1_src1     <= bus.i_src1;
            s1_rob_idx  <= bus.i_rob_idx;
            s1_rd_wen   <= bus.i_rd_wen;
            s1_iprd_idx <= bus.i_iprd_idx;
        end
        if (can_take[2] && s1_vld) begin
            sk_result[2]   <= alu_res;
            sk_rob_idx[2]  <= s1_rob_idx;
            sk_rd_wen[2]   <= s1_rd_wen;
            sk_iprd_idx[2] <= s1_iprd_idx;
        end
        for (int k = 3; k <= DEPTH; k++) begin
            if (can_take[k] && sk_vld[k-1]) begin
                sk_result[k]   <= sk_result[k-1];
                sk_rob_idx[k]  <= sk_rob_idx[k-1];
                sk_rd_wen[k]   <= sk_rd_wen[k-1];
                sk_iprd_idx[k] <= sk_iprd_idx[k-1];
            end
        end
    end

    assign bus.o_rdy             = can_take[1];
    assign bus.o_willwrite_vld   = s1_vld && s1_rd_wen && !bus.i_flush;
    assign bus.o_willwrite_rdidx = s1_iprd_idx;
    assign bus.o_willwrite_data  = alu_res;
    assign bus.o_vld             = sk_vld[DEPTH];
    assign bus.o_rob_idx         = sk_rob_idx[DEPTH];
    assign bus.o_rd_wen          = sk_rd_wen[DEPTH];
    assign bus.o_iprd_idx        = sk_iprd_idx[DEPTH];
    assign bus.o_result          = sk_result[DEPTH];
    assign bus.o_op_cnt          = op_cnt_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a DEPTH=2 unit for arithmetic and latency, a DEPTH=3
// unit for stall, flush and reset behaviour. Outputs are sampled on the falling edge.
module tb_alu_pipe;
    localparam logic [4:0] OP_LUI = 5'd0,  OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_ADDW = 5'd3;
    localparam logic [4:0] OP_SUBW = 5'd4, OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_SLLW = 5'd8, OP_SRLW = 5'd9, OP_SRAW = 5'd10, OP_XOR = 5'd11;
    localparam logic [4:0] OP_OR = 5'd12,  OP_AND = 5'd13, OP_SLT = 5'd14, OP_SLTU = 5'd15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        vld, rd_wen, flush, en2, en3, wb2, wb3;
    logic [4:0]  op;
    logic [63:0] src0, src1;
    logic [6:0]  rob, prd;

    alu_pipe_if #(.XLEN(64), .ROBW(7), .PRW(7)) if2 ();
    alu_pipe_if #(.XLEN(64), .ROBW(7), .PRW(7)) if3 ();

    assign if2.i_vld = vld && en2;   assign if3.i_vld = vld && en3;
    assign if2.i_op = op;            assign if3.i_op = op;
    assign if2.i_src0 = src0;        assign if3.i_src0 = src0;
    assign if2.i_src1 = src1;        assign if3.i_src1 = src1;
    assign if2.i_rob_idx = rob;      assign if3.i_rob_idx = rob;
    assign if2.i_rd_wen = rd_wen;    assign if3.i_rd_wen = rd_wen;
    assign if2.i_iprd_idx = prd;     assign if3.i_iprd_idx = prd;
    assign if2.i_flush = flush;      assign if3.i_flush = flush;
    assign if2.i_wb_rdy = wb2;       assign if3.i_wb_rdy = wb3;

    alu_pipe #(.XLEN(64), .DEPTH(2), .ROBW(7), .PRW(7)) u_d2 (.clk(clk), .rst(rst), .bus(if2.slave));
    alu_pipe #(.XLEN(64), .DEPTH(3), .ROBW(7), .PRW(7)) u_d3 (.clk(clk), .rst(rst), .bus(if3.slave));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] e;
    } vec_t;
    vec_t        vecs[$];
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [6:0] r);
        vld = 1'b1; op = o; src0 = a; src1 = b; rob = r; rd_wen = 1'b1; prd = r;
    endtask

    task automatic add_vec(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] e);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.e = e;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; rd_wen = 1'b0; flush = 1'b0;
        en2 = 1'b1; en3 = 1'b0; wb2 = 1'b1; wb3 = 1'b1;
        op = '0; src0 = '0; src1 = '0; rob = '0; prd = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state of both units
        @(negedge clk);
        chk("rst_d2_vld", {63'd0, if2.o_vld}, 64'd0);
        chk("rst_d2_rdy", {63'd0, if2.o_rdy}, 64'd1);
        chk("rst_d2_cnt", {32'd0, if2.o_op_cnt}, 64'd0);
        chk("rst_d2_ww",  {63'd0, if2.o_willwrite_vld}, 64'd0);
        chk("rst_d3_vld", {63'd0, if3.o_vld}, 64'd0);
        chk("rst_d3_cnt", {32'd0, if3.o_op_cnt}, 64'd0);
        tick();

        // DEPTH=2 latency: add 5+7 accepted in cycle 0
        drive(OP_ADD, 64'd5, 64'd7, 7'd3); prd = 7'd9;
        @(negedge clk);
        chk("t1_rdy_c0", {63'd0, if2.o_rdy}, 64'd1);
        chk("t1_ww_c0",  {63'd0, if2.o_willwrite_vld}, 64'd0);
        tick();
        vld = 1'b0;
        @(negedge clk);
        chk("t1_ww_vld_c1",  {63'd0, if2.o_willwrite_vld}, 64'd1);
        chk("t1_ww_data_c1", if2.o_willwrite_data, 64'd12);
        chk("t1_ww_rd_c1",   {57'd0, if2.o_willwrite_rdidx}, 64'd9);
        chk("t1_vld_c1",     {63'd0, if2.o_vld}, 64'd0);
        tick();
        @(negedge clk);
        chk("t1_vld_c2", {63'd0, if2.o_vld}, 64'd1);
        chk("t1_res_c2", if2.o_result, 64'd12);
        chk("t1_rob_c2", {57'd0, if2.o_rob_idx}, 64'd3);
        chk("t1_rdw_c2", {63'd0, if2.o_rd_wen}, 64'd1);
        chk("t1_prd_c2", {57'd0, if2.o_iprd_idx}, 64'd9);
        chk("t1_cnt_c2", {32'd0, if2.o_op_cnt}, 64'd0);
        tick();
        @(negedge clk);
        chk("t1_vld_c3", {63'd0, if2.o_vld}, 64'd0);
        chk("t1_cnt_c3", {32'd0, if2.o_op_cnt}, 64'd1);

        // Arithmetic table, issued back-to-back on DEPTH=2
        add_vec(OP_SRAW, 64'h0000_0000_8000_0000, 64'd4,  64'hFFFF_FFFF_F800_0000);
        add_vec(OP_SRLW, 64'h0000_0000_8000_0000, 64'd4,  64'h0000_0000_0800_0000);
        add_vec(OP_SLT,  64'h8000_0000_0000_0000, 64'd1,  64'd1);
        add_vec(OP_SLTU, 64'h8000_0000_0000_0000, 64'd1,  64'd0);
        add_vec(OP_LUI,  64'd0, 64'h0000_0000_0008_0000,  64'hFFFF_FFFF_8000_0000);
        add_vec(OP_SUB,  64'd3, 64'd5,                    64'hFFFF_FFFF_FFFF_FFFE);
        add_vec(OP_ADDW, 64'h0000_0000_7FFF_FFFF, 64'd1,  64'hFFFF_FFFF_8000_0000);
        add_vec(OP_SUBW, 64'h0000_0001_0000_0000, 64'd1,  64'hFFFF_FFFF_FFFF_FFFF);
        add_vec(OP_SLL,  64'd1, 64'h7F,                   64'h8000_0000_0000_0000);
        add_vec(OP_SRL,  64'h8000_0000_0000_0000, 64'd63, 64'd1);
        add_vec(OP_SRA,  64'h8000_0000_0000_0000, 64'd60, 64'hFFFF_FFFF_FFFF_FFF8);
        add_vec(OP_SRA,  64'h8000_0000_0000_0000, 64'h40, 64'h8000_0000_0000_0000);
        add_vec(OP_SLLW, 64'hFFFF_FFFF_0000_0001, 64'd31, 64'hFFFF_FFFF_8000_0000);
        add_vec(OP_SRLW, 64'hFFFF_FFFF_8000_0000, 64'd0,  64'hFFFF_FFFF_8000_0000);
        add_vec(OP_SRAW, 64'h0000_0000_F000_0000, 64'd28, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec(OP_XOR,  64'hF0F0, 64'hFF00,              64'h0FF0);
        add_vec(OP_OR,   64'hF0F0, 64'hFF00,              64'hFFF0);
        add_vec(OP_AND,  64'hF0F0, 64'hFF00,              64'hF000);
        add_vec(OP_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,  64'd1);
        add_vec(OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,  64'd0);
        add_vec(OP_SLT,  64'd1, 64'h8000_0000_0000_0000,  64'd0);
        add_vec(OP_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,  64'd0);
        tick();
        for (int c = 0; c < vecs.size() + 2; c++) begin
            if (c < vecs.size()) begin
                vld = 1'b1; op = vecs[c].op; src0 = vecs[c].a; src1 = vecs[c].b;
                rob = 7'(c); rd_wen = c[0]; prd = 7'(c + 40);
                exp_q.push_back(vecs[c].e);
            end else begin
                vld = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("s%0d_rdy", c), {63'd0, if2.o_rdy}, 64'd1);
            if (c >= 1) begin
                chk($sformatf("s%0d_ww_vld", c - 1), {63'd0, if2.o_willwrite_vld},
                    {63'd0, ((c - 1) % 2 == 1)});
                chk($sformatf("s%0d_ww_data", c - 1), if2.o_willwrite_data, vecs[c-1].e);
            end
            if (c >= 2) begin
                chk($sformatf("s%0d_vld", c - 2), {63'd0, if2.o_vld}, 64'd1);
                chk($sformatf("s%0d_res_op%0d", c - 2, vecs[c-2].op), if2.o_result,
                    exp_q.pop_front());
                chk($sformatf("s%0d_rob", c - 2), {57'd0, if2.o_rob_idx}, 64'(c - 2));
            end
            tick();
        end
        @(negedge clk);
        chk("s_cnt", {32'd0, if2.o_op_cnt}, 64'(1 + vecs.size()));
        tick();

        // DEPTH=3 stall: five back-to-back ops, writeback blocked in cycles 4..7
        en2 = 1'b0; en3 = 1'b1; wb3 = 1'b1;
        drive(OP_ADD, 64'd0, 64'd1, 7'd16);
        @(negedge clk); chk("t4_rdy_c0", {63'd0, if3.o_rdy}, 64'd1);
        tick(); drive(OP_ADD, 64'd10, 64'd1, 7'd17);
        tick(); drive(OP_ADD, 64'd20, 64'd1, 7'd18);
        @(negedge clk); chk("t4_vld_c2", {63'd0, if3.o_vld}, 64'd0);
        tick(); drive(OP_ADD, 64'd30, 64'd1, 7'd19);
        @(negedge clk);
        chk("t4_vld_c3", {63'd0, if3.o_vld}, 64'd1);
        chk("t4_res_c3", if3.o_result, 64'd1);
        chk("t4_rob_c3", {57'd0, if3.o_rob_idx}, 64'd16);
        tick(); drive(OP_ADD, 64'd40, 64'd1, 7'd20); wb3 = 1'b0;
        for (int c = 4; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("t4_rdy_c%0d", c), {63'd0, if3.o_rdy}, 64'd0);
            chk($sformatf("t4_vld_c%0d", c), {63'd0, if3.o_vld}, 64'd1);
            chk($sformatf("t4_res_c%0d", c), if3.o_result, 64'd11);
            chk($sformatf("t4_rob_c%0d", c), {57'd0, if3.o_rob_idx}, 64'd17);
            chk($sformatf("t4_cnt_c%0d", c), {32'd0, if3.o_op_cnt}, 64'd1);
            tick();
        end
        wb3 = 1'b1;
        @(negedge clk);
        chk("t4_rdy_c8", {63'd0, if3.o_rdy}, 64'd1);
        chk("t4_res_c8", if3.o_result, 64'd11);
        tick(); vld = 1'b0;
        for (int c = 9; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("t4_vld_c%0d", c), {63'd0, if3.o_vld}, 64'd1);
            chk($sformatf("t4_res_c%0d", c), if3.o_result, 64'(10 * (c - 7) + 1));
            chk($sformatf("t4_rob_c%0d", c), {57'd0, if3.o_rob_idx}, 64'(c + 9));
            tick();
        end
        @(negedge clk);
        chk("t4_vld_c12", {63'd0, if3.o_vld}, 64'd0);
        chk("t4_cnt_c12", {32'd0, if3.o_op_cnt}, 64'd5);
        tick();

        // DEPTH=3 flush with three ops in flight and a new op offered
        drive(OP_ADD, 64'd100, 64'd0, 7'd32);
        tick(); drive(OP_ADD, 64'd200, 64'd0, 7'd33);
        tick(); drive(OP_ADD, 64'd300, 64'd0, 7'd34);
        @(negedge clk); chk("t5_ww_c2", {63'd0, if3.o_willwrite_vld}, 64'd1);
        tick(); drive(OP_OR, 64'd1, 64'd2, 7'd35); flush = 1'b1;
        @(negedge clk);
        chk("t5_rdy_flush", {63'd0, if3.o_rdy}, 64'd1);
        chk("t5_vld_flush", {63'd0, if3.o_vld}, 64'd1);
        chk("t5_res_flush", if3.o_result, 64'd100);
        chk("t5_ww_flush",  {63'd0, if3.o_willwrite_vld}, 64'd0);
        tick(); flush = 1'b0; vld = 1'b0;
        for (int c = 4; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("t5_vld_c%0d", c), {63'd0, if3.o_vld}, 64'd0);
            chk($sformatf("t5_cnt_c%0d", c), {32'd0, if3.o_op_cnt}, 64'd6);
            tick();
        end
        drive(OP_XOR, 64'hF0F0, 64'hFF00, 7'd36);
        tick(); vld = 1'b0;
        @(negedge clk); chk("t5_post_vld_c1", {63'd0, if3.o_vld}, 64'd0);
        tick();
        @(negedge clk); chk("t5_post_vld_c2", {63'd0, if3.o_vld}, 64'd0);
        tick();
        @(negedge clk);
        chk("t5_post_vld_c3", {63'd0, if3.o_vld}, 64'd1);
        chk("t5_post_res_c3", if3.o_result, 64'h0FF0);
        chk("t5_post_rob_c3", {57'd0, if3.o_rob_idx}, 64'd36);
        tick();
        @(negedge clk); chk("t5_post_cnt", {32'd0, if3.o_op_cnt}, 64'd7);

        // DEPTH=3 reset with full pipe and blocked writeback
        wb3 = 1'b0;
        drive(OP_ADD, 64'd1, 64'd1, 7'd40);
        tick(); drive(OP_ADD, 64'd2, 64'd1, 7'd41);
        tick(); drive(OP_ADD, 64'd3, 64'd1, 7'd42);
        tick(); drive(OP_ADD, 64'd4, 64'd1, 7'd43);
        @(negedge clk);
        chk("t6_rdy_full", {63'd0, if3.o_rdy}, 64'd0);
        chk("t6_vld_full", {63'd0, if3.o_vld}, 64'd1);
        rst = 1'b1;
        tick(); rst = 1'b0; vld = 1'b0;
        @(negedge clk);
        chk("t6_vld_rst", {63'd0, if3.o_vld}, 64'd0);
        chk("t6_cnt_rst", {32'd0, if3.o_op_cnt}, 64'd0);
        chk("t6_rdy_rst", {63'd0, if3.o_rdy}, 64'd1);
        chk("t6_ww_rst",  {63'd0, if3.o_willwrite_vld}, 64'd0);
        wb3 = 1'b1;
        tick();

        // Undefined opcode completes with a zero result
        drive(5'd31, 64'd5, 64'd7, 7'd50);
        tick(); vld = 1'b0;
        @(negedge clk);
        chk("t6_ill_ww_vld",  {63'd0, if3.o_willwrite_vld}, 64'd1);
        chk("t6_ill_ww_data", if3.o_willwrite_data, 64'd0);
        tick(); tick();
        @(negedge clk);
        chk("t6_ill_vld", {63'd0, if3.o_vld}, 64'd1);
        chk("t6_ill_res", if3.o_result, 64'd0);
        chk("t6_ill_rob", {57'd0, if3.o_rob_idx}, 64'd50);
        tick();
        @(negedge clk);
        chk("t6_ill_cnt", {32'd0, if3.o_op_cnt}, 64'd1);
        chk("t6_ill_done", {63'd0, if3.o_vld}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
